// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// LSU state type and the natural-alignment test.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_DONE
    } lsu_state_e;

    // Unsupported encodings behave as word accesses, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_B || f3 == F3_BU) return 1'b0;
        if (f3 == F3_H || f3 == F3_HU) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Handshaked data-SRAM bus between the load/store unit (master) and the SRAM (slave).
interface dmem_lsu_if #(
    parameter int unsigned AW = 30
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: funct3 + byte offset -> store strobes, replicated store
// data and the selected, sign/zero-extended load value.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords use off[1] only and words ignore the offset, which gives the
    // natural-alignment masking for free.
    always_comb begin
        byte_sel  = rdata[{off, 3'b000} +: 8];
        half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
        wstrb     = 4'hF;
        wdata_sh  = wdata;
        rdata_ext = rdata;
        case (funct3)
            F3_B, F3_BU: begin
                wstrb     = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_BU) ? {24'h0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                wstrb     = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = (funct3 == F3_HU) ? {16'h0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a handshaked data SRAM.
// Optional define DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being masked.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned AW             = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              acc_err,
    dmem_lsu_if.master        mem
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        latch;

    logic [3:0]  strb;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;

    dmem_lane_align u_align (
        .funct3    (f3_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem.mem_rdata),
        .wstrb     (strb),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LSU_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            if (latch) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        latch     = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    latch   = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LSU_REQ;
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d   = LSU_DONE;
                        err_d     = 1'b1;
                        ld_data_d = '0;
                    end
`endif
                end
            end
            LSU_REQ: begin
                // Ready in the last counted cycle still completes normally.
                if (mem.mem_ready) begin
                    state_d = LSU_DONE;
                    if (!we_q) ld_data_d = rdata_ext;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = LSU_DONE;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    assign mem.mem_req   = (state_q == LSU_REQ);
    assign mem.mem_we    = mem.mem_req & we_q;
    assign mem.mem_wstrb = mem.mem_we ? strb : 4'h0;
    assign mem.mem_addr  = addr_q[AW+1:2];
    assign mem.mem_wdata = wdata_sh;

    // Gated by rst so the pipeline is released the moment reset asserts.
    assign stall    = rst & req_valid & (state_q != LSU_DONE);
    assign ld_valid = (state_q == LSU_DONE) & ~we_q;
    assign acc_err  = (state_q == LSU_DONE) & err_q;
    assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-level memory reference model, SRAM responder
// with programmable latency, decoupled monitor comparing requests and load results.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int unsigned TO = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        ld_valid;
        logic        acc_err;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } rq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        acc_err;

    dmem_lsu_if #(.AW(30)) mem_bus ();

    dmem_lsu #(.TIMEOUT_CYCLES(TO), .AW(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .acc_err    (acc_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    ev_t         ev_q[$];
    rq_t         rq_q[$];
    logic [31:0] sram [64];
    logic [7:0]  ref_bytes [256];
    int          resp_delay = 0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 1;
            F3_H, F3_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    task automatic preload(input int unsigned w, input logic [31:0] v);
        sram[w] = v;
        for (int unsigned i = 0; i < 4; i++) ref_bytes[4*w + i] = v[8*i +: 8];
    endtask

    // SRAM slave: answers mem_req after resp_delay wait cycles (negative = never).
    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = $urandom();
            if (mem_bus.mem_req) begin
                if (resp_delay >= 0 && wait_cnt == resp_delay) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_rdata = sram[mem_bus.mem_addr[5:0]];
                    if (mem_bus.mem_we)
                        for (int unsigned b = 0; b < 4; b++)
                            if (mem_bus.mem_wstrb[b])
                                sram[mem_bus.mem_addr[5:0]][8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result or an accepted request.
    initial begin : monitor
        ev_t e;
        rq_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ld_valid || acc_err) begin
                    if (ev_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: ld_valid=%0b acc_err=%0b, none expected", ld_valid, acc_err);
                    end else begin
                        e = ev_q.pop_front();
                        check("ld_valid", 32'(ld_valid), 32'(e.ld_valid));
                        check("acc_err", 32'(acc_err), 32'(e.acc_err));
                        if (e.ld_valid) check("ld_data", ld_data, e.data);
                    end
                end
                if (mem_bus.mem_req && mem_bus.mem_ready) begin
                    if (rq_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_request: addr=0x%08h, none expected", mem_bus.mem_addr);
                    end else begin
                        r = rq_q.pop_front();
                        check("mem_addr", 32'(mem_bus.mem_addr), 32'(r.addr));
                        check("mem_we", 32'(mem_bus.mem_we), 32'(r.we));
                        check("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(r.wstrb));
                        if (r.we) check("mem_wdata", mem_bus.mem_wdata, r.wdata);
                    end
                end
            end
        end
    end

    // Issue one access; expectations come from the byte-level reference model.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int delay);
        int unsigned sz, lo, bi;
        logic [31:0] al, v;
        bit uns, mis, trap, tmo;
        ev_t e;
        rq_t r;
        int stall_n, req_n, exp_stall, exp_req;

        sz   = size_of(f3);
        uns  = (f3 == F3_BU || f3 == F3_HU);
        al   = addr & ~32'(sz - 1);
        mis  = (addr[1:0] & 2'(sz - 1)) != 2'b00;
        trap = TRAP && mis;
        tmo  = (delay < 0) && !trap;
        lo   = al % 4;
        bi   = al % 256;

        if (!trap && !tmo) begin
            r.addr  = al[31:2];
            r.we    = we;
            r.wstrb = '0;
            r.wdata = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (we && i >= lo && i < lo + sz) r.wstrb[i] = 1'b1;
                r.wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
            end
            rq_q.push_back(r);
        end

        if (!we) begin
            v = '0;
            if (!trap && !tmo) begin
                for (int unsigned i = 0; i < sz; i++) v[8*i +: 8] = ref_bytes[bi + i];
                if (!uns && sz < 4 && v[8*sz-1])
                    for (int unsigned i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            e.ld_valid = 1'b1;
            e.acc_err  = trap | tmo;
            e.data     = v;
            ev_q.push_back(e);
        end else if (trap || tmo) begin
            e.ld_valid = 1'b0;
            e.acc_err  = 1'b1;
            e.data     = '0;
            ev_q.push_back(e);
        end else begin
            for (int unsigned i = 0; i < sz; i++) ref_bytes[bi + i] = wdata[8*i +: 8];
        end

        exp_req   = trap ? 0 : (tmo ? int'(TO) : delay + 1);
        exp_stall = trap ? 1 : (tmo ? int'(TO) + 1 : delay + 2);

        resp_delay = delay;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        stall_n = 0;
        req_n   = 0;
        for (int c = 0; c < int'(TO) + 20; c++) begin
            @(negedge clk);
            if (mem_bus.mem_req) req_n++;
            if (!stall) break;
            stall_n++;
        end
        check("stall_cycles", 32'(stall_n), 32'(exp_stall));
        check("mem_req_cycles", 32'(req_n), 32'(exp_req));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        for (int unsigned w = 0; w < 64; w++) preload(w, $urandom());

        // Reset state, with a request pending to show stall is held low.
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
        check("rst_ld_valid", 32'(ld_valid), 32'h0);
        check("rst_acc_err", 32'(acc_err), 32'h0);
        check("rst_ld_data", ld_data, 32'h0);
        check("rst_mem_bus", {mem_bus.mem_we, mem_bus.mem_wstrb, 27'(mem_bus.mem_addr)}, 32'h0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        preload(4, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0010, 32'h0, F3_W, 0);
        preload(4, 32'h80AA_5511);
        access(1'b0, 32'h0000_0013, 32'h0, F3_B, 0);
        access(1'b0, 32'h0000_0013, 32'h0, F3_BU, 1);
        access(1'b0, 32'h0000_0012, 32'h0, F3_H, 2);
        access(1'b1, 32'h0000_0021, 32'h0000_00C3, F3_B, 1);
        access(1'b0, 32'h0000_0020, 32'h0, F3_W, 0);
        access(1'b1, 32'h0000_0022, 32'h1234_5678, F3_W, 0);
        access(1'b0, 32'h0000_0030, 32'h0, F3_W, -1);
        access(1'b0, 32'h0000_0034, 32'h0, F3_HU, int'(TO) - 1);
        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3'b011, 0);
        access(1'b0, 32'h0000_0042, 32'h0, 3'b111, 0);

        // Reset while the access is waiting in REQ.
        resp_delay = -1;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h0000_0050;
        req_funct3 = F3_W;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_mem_req", 32'(mem_bus.mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("reset_mem_req", 32'(mem_bus.mem_req), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        access(1'b0, 32'h0000_0050, 32'h0, F3_W, 0);

        for (int unsigned n = 0; n < 120; n++) begin
            access(1'($urandom_range(0, 1)), $urandom(), $urandom(), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        check("events_drained", 32'(ev_q.size()), 32'h0);
        check("requests_drained", 32'(rq_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
